// File: rtl/nand_flash_controller.sv
// rtl/nand_flash_controller.sv - page-level NAND flash controller with host page buffer (optional status check: CTRL_STATUS_CHECK_EN)
module nand_flash_controller #(
    parameter int PAGE_SIZE = 16,
    parameter int WB_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [15:0]                  cmd_addr,
    input  logic                         hbuf_we,
    input  logic [$clog2(PAGE_SIZE)-1:0] hbuf_addr,
    input  logic [7:0]                   hbuf_wdata,
    output logic [7:0]                   hbuf_rdata,
    output logic                         done,
    output logic                         status_fail,
    output logic                         nf_ce_n,
    output logic                         nf_cle,
    output logic                         nf_ale,
    output logic                         nf_we_n,
    output logic                         nf_re_n,
    output logic [7:0]                   nf_dq_out,
    output logic                         nf_dq_oe,
    input  logic [7:0]                   nf_dq_in,
    input  logic                         nf_rb_n
);
    localparam int AW = $clog2(PAGE_SIZE);
    localparam int CW = 16;
    localparam logic [CW-1:0] LAST_BYTE = CW'(PAGE_SIZE - 1);
    localparam logic [CW-1:0] WB_CNT    = CW'(WB_CYCLES);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD1, S_ADDR, S_DIN, S_CMD2,
        S_WAITB, S_DOUT, S_STAT_CMD, S_STAT_RD, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    mem_q [PAGE_SIZE];

    logic [CW-1:0] last_addr;
    logic [7:0]    addr_byte;
    logic [7:0]    cmd1_byte;
    logic [7:0]    cmd2_byte;
    logic          write_st;
    logic          read_st;

`ifdef CTRL_STATUS_CHECK_EN
    logic status_q, status_d;
`endif

    // Erase sends only the two row bytes; read/program prefix a zero column byte.
    always_comb begin
        last_addr = (op_q == OP_ERASE) ? CW'(1) : CW'(2);
        addr_byte = 8'h00;
        if (op_q == OP_ERASE) begin
            addr_byte = (cnt_q == '0) ? addr_q[7:0] : addr_q[15:8];
        end else if (cnt_q == CW'(1)) begin
            addr_byte = addr_q[7:0];
        end else if (cnt_q == CW'(2)) begin
            addr_byte = addr_q[15:8];
        end
        case (op_q)
            OP_READ:  begin cmd1_byte = 8'h00; cmd2_byte = 8'h30; end
            OP_PROG:  begin cmd1_byte = 8'h80; cmd2_byte = 8'h10; end
            OP_ERASE: begin cmd1_byte = 8'h60; cmd2_byte = 8'hD0; end
            default:  begin cmd1_byte = 8'hFF; cmd2_byte = 8'h00; end
        endcase
    end

    // Next-state logic; bus states take two clocks, advancing when phase_q is 1.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
`ifdef CTRL_STATUS_CHECK_EN
        status_d = status_q;
`endif
        case (state_q)
            S_IDLE: begin
                phase_d = 1'b0;
                if (cmd_valid) begin
                    state_d = S_CMD1;
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    cnt_d   = '0;
                end
            end
            S_CMD1: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    cnt_d   = '0;
                    state_d = (op_q == OP_RESET) ? S_WAITB : S_ADDR;
                end
            end
            S_ADDR: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (cnt_q == last_addr) begin
                        cnt_d   = '0;
                        state_d = (op_q == OP_PROG) ? S_DIN : S_CMD2;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DIN: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = S_CMD2;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_CMD2: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    cnt_d   = '0;
                    state_d = S_WAITB;
                end
            end
            S_WAITB: begin
                phase_d = 1'b0;
                if (cnt_q != WB_CNT) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (nf_rb_n) begin
                    cnt_d = '0;
                    case (op_q)
                        OP_READ:  state_d = S_DOUT;
                        OP_RESET: state_d = S_DONE;
`ifdef CTRL_STATUS_CHECK_EN
                        default:  state_d = S_STAT_CMD;
`else
                        default:  state_d = S_DONE;
`endif
                    endcase
                end
            end
            S_DOUT: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_STAT_CMD: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    state_d = S_STAT_RD;
                end
            end
            S_STAT_RD: begin
                phase_d = ~phase_q;
`ifdef CTRL_STATUS_CHECK_EN
                if (!phase_q) begin
                    status_d = nf_dq_in[0];
                end
`endif
                if (phase_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                phase_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                phase_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
        end
    end

`ifdef CTRL_STATUS_CHECK_EN
    // Status flag from the last program/erase status read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q <= 1'b0;
        end else begin
            status_q <= status_d;
        end
    end
    assign status_fail = status_q;
`else
    assign status_fail = 1'b0;
`endif

    // Page buffer: host writes only while idle, NAND reads land during DOUT; never cleared.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && hbuf_we) begin
            mem_q[hbuf_addr] <= hbuf_wdata;
        end else if (state_q == S_DOUT && !phase_q) begin
            mem_q[cnt_q[AW-1:0]] <= nf_dq_in;
        end
    end

    assign hbuf_rdata = mem_q[hbuf_addr];

    // NAND pins decoded from state and bus phase.
    always_comb begin
        write_st  = (state_q == S_CMD1) || (state_q == S_ADDR) || (state_q == S_DIN) ||
                    (state_q == S_CMD2) || (state_q == S_STAT_CMD);
        read_st   = (state_q == S_DOUT) || (state_q == S_STAT_RD);
        cmd_ready = (state_q == S_IDLE);
        done      = (state_q == S_DONE);
        nf_ce_n   = (state_q == S_IDLE) || (state_q == S_DONE);
        nf_cle    = (state_q == S_CMD1) || (state_q == S_CMD2) || (state_q == S_STAT_CMD);
        nf_ale    = (state_q == S_ADDR);
        nf_we_n   = !(write_st && !phase_q);
        nf_re_n   = !(read_st && !phase_q);
        nf_dq_oe  = write_st;
        case (state_q)
            S_CMD1:     nf_dq_out = cmd1_byte;
            S_ADDR:     nf_dq_out = addr_byte;
            S_DIN:      nf_dq_out = mem_q[cnt_q[AW-1:0]];
            S_CMD2:     nf_dq_out = cmd2_byte;
            S_STAT_CMD: nf_dq_out = 8'h70;
            default:    nf_dq_out = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_nand_flash_controller.sv
// tb/tb_nand_flash_controller.sv - self-checking bench for nand_flash_controller
module tb_nand_flash_controller;
    localparam int PS = 16;
    localparam int WB = 2;
`ifdef CTRL_STATUS_CHECK_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif
    localparam logic [16:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [15:0] cmd_addr = 16'h0;
    logic       hbuf_we = 1'b0;
    logic [3:0] hbuf_addr = 4'h0;
    logic [7:0] hbuf_wdata = 8'h0;
    logic [7:0] hbuf_rdata;
    logic       done, status_fail;
    logic       nf_ce_n, nf_cle, nf_ale, nf_we_n, nf_re_n, nf_dq_oe;
    logic [7:0] nf_dq_out;
    logic [7:0] nf_dq_in = 8'h00;
    logic       nf_rb_n = 1'b1;

    nand_flash_controller #(.PAGE_SIZE(PS), .WB_CYCLES(WB)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .hbuf_we(hbuf_we), .hbuf_addr(hbuf_addr),
        .hbuf_wdata(hbuf_wdata), .hbuf_rdata(hbuf_rdata), .done(done), .status_fail(status_fail),
        .nf_ce_n(nf_ce_n), .nf_cle(nf_cle), .nf_ale(nf_ale), .nf_we_n(nf_we_n), .nf_re_n(nf_re_n),
        .nf_dq_out(nf_dq_out), .nf_dq_oe(nf_dq_oe), .nf_dq_in(nf_dq_in), .nf_rb_n(nf_rb_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // NAND device model state: bus log entries are {kind, byte}, kind 1=cmd 2=addr 3=data.
    logic [9:0] log_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] page_q[$];
    logic [7:0] buf_model [PS];
    logic [7:0] status_byte = 8'h00;
    logic [7:0] last_cmd = 8'h00;
    logic       stat_exp = 1'b0;
    int rd_idx = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    int proto_err = 0;
    bit poke = 1'b0;

    // Device model, observed mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            nf_rb_n  = 1'b1;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) nf_rb_n = 1'b1;
            end
            if (!nf_ce_n && !nf_we_n) begin
                if (!nf_dq_oe) proto_err++;
                log_q.push_back({nf_cle ? 2'd1 : (nf_ale ? 2'd2 : 2'd3), nf_dq_out});
                if (nf_cle) begin
                    last_cmd = nf_dq_out;
                    if (nf_dq_out == 8'h00) rd_idx = 0;
                    if ((nf_dq_out == 8'h30 || nf_dq_out == 8'h10 || nf_dq_out == 8'hD0 ||
                         nf_dq_out == 8'hFF) && busy_len > 0) begin
                        nf_rb_n  = 1'b0;
                        busy_cnt = busy_len;
                    end
                end
            end
            if (!nf_ce_n && !nf_re_n) begin
                if (nf_dq_oe) proto_err++;
                if (last_cmd == 8'h70) begin
                    nf_dq_in = status_byte;
                end else begin
                    nf_dq_in = (rd_idx < page_q.size()) ? page_q[rd_idx] : 8'hEE;
                    rd_idx++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected bus sequence derived from the ONFI command rules.
    task automatic build_exp(input logic [1:0] op, input logic [15:0] a);
        exp_q.delete();
        case (op)
            2'b00: begin
                exp_q.push_back({2'd1, 8'h00}); exp_q.push_back({2'd2, 8'h00});
                exp_q.push_back({2'd2, a[7:0]}); exp_q.push_back({2'd2, a[15:8]});
                exp_q.push_back({2'd1, 8'h30});
            end
            2'b01: begin
                exp_q.push_back({2'd1, 8'h80}); exp_q.push_back({2'd2, 8'h00});
                exp_q.push_back({2'd2, a[7:0]}); exp_q.push_back({2'd2, a[15:8]});
                for (int i = 0; i < PS; i++) exp_q.push_back({2'd3, buf_model[i]});
                exp_q.push_back({2'd1, 8'h10});
                if (STAT_EN) exp_q.push_back({2'd1, 8'h70});
            end
            2'b10: begin
                exp_q.push_back({2'd1, 8'h60});
                exp_q.push_back({2'd2, a[7:0]}); exp_q.push_back({2'd2, a[15:8]});
                exp_q.push_back({2'd1, 8'hD0});
                if (STAT_EN) exp_q.push_back({2'd1, 8'h70});
            end
            default: exp_q.push_back({2'd1, 8'hFF});
        endcase
    endtask

    task automatic host_write(input int i, input logic [7:0] d);
        @(negedge clk);
        hbuf_we = 1'b1; hbuf_addr = 4'(i); hbuf_wdata = d;
        @(negedge clk);
        hbuf_we = 1'b0;
        buf_model[i] = d;
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < PS; i++) begin
            @(negedge clk);
            hbuf_addr = 4'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), hbuf_rdata, buf_model[i]);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, output int ncyc);
        int n;
        log_q.delete();
        build_exp(op, a);
        @(negedge clk);
        check("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 16'($urandom);
        check("ready_busy", cmd_ready, 0);
        if (poke) begin
            hbuf_we = 1'b1; hbuf_addr = 4'd3; hbuf_wdata = 8'h5A;
        end
        ncyc = 1;
        while (done !== 1'b1 && ncyc < 3000) begin
            @(negedge clk);
            ncyc++;
        end
        hbuf_we = 1'b0;
        check("done_seen", done, 1);
        @(negedge clk);
        check("done_pulse", {done, cmd_ready}, 2'b01);
        check("log_len", log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("bus[%0d]", i), log_q[i], exp_q[i]);
        if (op == 2'b00) for (int i = 0; i < PS; i++) buf_model[i] = page_q[i];
        if ((op == 2'b01 || op == 2'b10) && STAT_EN) stat_exp = status_byte[0];
        check("status_fail", status_fail, stat_exp);
    endtask

    initial begin
        int ncyc;
        int seen;
        logic [1:0] op;
        for (int i = 0; i < PS; i++) buf_model[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_vals", {cmd_ready, done, status_fail, nf_ce_n, nf_cle, nf_ale, nf_we_n,
                             nf_re_n, nf_dq_oe, nf_dq_out}, RST_VEC);
        rst_n = 1'b1;

        // Program 0x00..0x0F to row 0x1234.
        for (int i = 0; i < PS; i++) host_write(i, 8'(i));
        busy_len = 3; status_byte = 8'h00;
        run_op(2'b01, 16'h1234, ncyc);

        // Read row 0x0005 with host writes attempted throughout.
        page_q.delete();
        for (int i = 0; i < PS; i++) page_q.push_back(8'hA0 + 8'(i));
        busy_len = 6; poke = 1'b1;
        run_op(2'b00, 16'h0005, ncyc);
        poke = 1'b0;
        check_buf("rd_buf");

        // Erase row 0x00FF with ready device: exact latency and failing status.
        busy_len = 0; status_byte = 8'h01;
        run_op(2'b10, 16'h00FF, ncyc);
        check("erase_latency", ncyc, 2 + 4 + 2 + (WB + 1) + (STAT_EN ? 4 : 0) + 1);

        // Reset op with a 10-cycle busy period: done one cycle after rb_n rises.
        busy_len = 10;
        run_op(2'b11, 16'h0000, ncyc);
        check("reset_op_latency", ncyc, 1 + busy_len + 1);

        // Randomized operations.
        for (int k = 0; k < 6; k++) begin
            op = 2'($urandom_range(0, 3));
            busy_len = $urandom_range(0, 6);
            status_byte = 8'($urandom);
            poke = 1'($urandom);
            if (op == 2'b01) for (int i = 0; i < PS; i++) host_write(i, 8'($urandom));
            page_q.delete();
            for (int i = 0; i < PS; i++) page_q.push_back(8'($urandom));
            run_op(op, 16'($urandom), ncyc);
            poke = 1'b0;
            check_buf($sformatf("rand_buf%0d", k));
        end

        // Reset asserted during the data-in phase of a program.
        busy_len = 0;
        for (int i = 0; i < PS; i++) host_write(i, 8'($urandom));
        log_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 16'hBEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 0;
        while (log_q.size() < 7 && seen < 200) begin
            @(negedge clk);
            seen++;
        end
        check("din_reached", (log_q.size() >= 7), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        stat_exp = 1'b0;
        check("midop_reset_vals", {cmd_ready, done, status_fail, nf_ce_n, nf_cle, nf_ale, nf_we_n,
                                   nf_re_n, nf_dq_oe, nf_dq_out}, RST_VEC);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("no_done_after_reset", seen, 0);
        check("ready_after_reset", cmd_ready, 1);
        check_buf("buf_kept");

        check("protocol_errors", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
